// File: rtl/i2s_rx_arb_pkg.sv
// Shared constants, channel-id type and round-robin pick helper for the I2S RX stream arbiter.
package i2s_rx_arb_pkg;

  localparam int unsigned I2S_ARB_MAX_CH = 8;
  localparam int unsigned I2S_ARB_DW     = 32;

  typedef logic [$clog2(I2S_ARB_MAX_CH)-1:0] ch_id_t;

  typedef struct packed {
    logic   found;
    ch_id_t idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo num_ch.
  function automatic rr_pick_t rr_pick(input logic [I2S_ARB_MAX_CH-1:0] req,
                                       input ch_id_t                    ptr,
                                       input int unsigned               num_ch);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < I2S_ARB_MAX_CH; i++) begin
      j = 32'(ptr) + i;
      if (j >= num_ch) j = j - num_ch;
      if (!res.found && (i < num_ch) && req[ch_id_t'(j)]) begin
        res.found = 1'b1;
        res.idx   = ch_id_t'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_rx_arb_fifo.sv
// Per-channel synchronous FIFO with flush; extra pointer bit separates full from empty.
module i2s_rx_arb_fifo
  import i2s_rx_arb_pkg::*;
#(
  parameter int unsigned DW    = I2S_ARB_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty_o = (r_wptr == r_rptr);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/i2s_rx_stream_arb.sv
// Merges NUM_CH I2S RX word streams onto one uDMA stream: per-channel FIFOs, round-robin
// grant, single output register, sticky per-channel overflow flags.
module i2s_rx_stream_arb
  import i2s_rx_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_en_i,
  input  logic [NUM_CH-1:0]         cfg_ch_mask_i,
  input  logic [NUM_CH*DW-1:0]      in_data_i,
  input  logic [NUM_CH-1:0]         in_valid_i,
  output logic [NUM_CH-1:0]         in_ready_o,
  output logic [DW-1:0]             out_data_o,
  output logic [$clog2(NUM_CH)-1:0] out_id_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NUM_CH-1:0]         err_ovf_o,
  input  logic                      err_clr_i
);

  localparam int unsigned IW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]         w_active;
  logic [NUM_CH-1:0]         w_full;
  logic [NUM_CH-1:0]         w_empty;
  logic [NUM_CH-1:0]         w_req;
  logic [NUM_CH-1:0]         w_push;
  logic [NUM_CH-1:0]         w_pop;
  logic [NUM_CH-1:0]         w_ovf;
  logic [NUM_CH-1:0][DW-1:0] w_fifo_data;
  logic [DW-1:0]             w_sel_data;
  logic                      w_load;
  rr_pick_t                  w_pick;
  ch_id_t                    w_ptr_nxt;

  logic                      r_valid;
  logic [DW-1:0]             r_data;
  logic [IW-1:0]             r_id;
  ch_id_t                    r_ptr;
  logic [NUM_CH-1:0]         r_err;

  assign w_active = {NUM_CH{cfg_en_i}} & cfg_ch_mask_i;
  // Gated by reset so in_ready_o reads 0 while reset is held.
  assign in_ready_o = w_active & ~w_full & {NUM_CH{rstn_i}};
  assign w_push     = in_valid_i & in_ready_o;
  assign w_ovf      = in_valid_i & w_active & w_full;
  // Inactive channels are being flushed and must not feed the output register.
  assign w_req      = w_active & ~w_empty;
  assign w_load     = ~r_valid | out_ready_i;
  assign w_pick     = rr_pick(I2S_ARB_MAX_CH'(w_req), r_ptr, NUM_CH);
  assign w_ptr_nxt  = (32'(w_pick.idx) == NUM_CH - 1) ? '0 : w_pick.idx + ch_id_t'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    i2s_rx_arb_fifo #(
      .DW   (DW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .flush_i(~w_active[g]),
      .push_i (w_push[g]),
      .data_i (in_data_i[g*DW +: DW]),
      .pop_i  (w_pop[g]),
      .data_o (w_fifo_data[g]),
      .full_o (w_full[g]),
      .empty_o(w_empty[g])
    );
  end

  always_comb begin
    w_pop      = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_id_t'(i) == w_pick.idx) begin
        w_sel_data = w_fifo_data[i];
        w_pop[i]   = w_load & w_pick.found;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_load) begin
      r_valid <= w_pick.found;
      if (w_pick.found) begin
        r_data <= w_sel_data;
        r_id   <= IW'(w_pick.idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr <= '0;
    end else if (!cfg_en_i) begin
      r_ptr <= '0;
    end else if (w_load && w_pick.found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // A new overflow beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr_i ? '0 : r_err) | w_ovf;
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_id_o    = r_id;
  assign err_ovf_o   = r_err;

endmodule

// File: tb/tb_i2s_rx_stream_arb.sv
// Directed self-checking bench for i2s_rx_stream_arb (NUM_CH=2, DW=32, DEPTH=2).
module tb_i2s_rx_stream_arb;

  logic        clk;
  logic        rstn;
  logic        cfg_en;
  logic [1:0]  mask;
  logic [63:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] out_data;
  logic [0:0]  out_id;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  err_ovf;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  i2s_rx_stream_arb #(
    .NUM_CH(2),
    .DW    (32),
    .DEPTH (2)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cfg_en_i     (cfg_en),
    .cfg_ch_mask_i(mask),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_id_o     (out_id),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .err_ovf_o    (err_ovf),
    .err_clr_i    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  hs;
    logic [31:0] d0, d1, e0, e1;
    logic        exp_id;

    rstn = 1'b0; cfg_en = 1'b0; mask = 2'b00; in_data = '0; in_valid = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_err", 32'(err_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rstn = 1'b1; cfg_en = 1'b1; mask = 2'b11; out_ready = 1'b1;
    tick();
    chk("en_ready", 32'(in_ready), 32'd3);

    // Single word on ch0: valid two edges after handshake, for one cycle
    in_valid = 2'b01; in_data[31:0] = 32'hA5A50001;
    tick();
    in_valid = 2'b00;
    chk("single_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hA5A50001);
    chk("single_id", 32'(out_id), 32'd0);
    tick();
    chk("single_gone", 32'(out_valid), 32'd0);

    // Fairness: round-robin pointer is 1 after the ch0 grant, so ch1 goes first
    d0 = 32'h100; d1 = 32'h200; e0 = 32'h100; e1 = 32'h200; exp_id = 1'b1;
    in_data = {d1, d0}; in_valid = 2'b11;
    for (int n = 0; n < 8; n++) begin
      hs = in_valid & in_ready;
      tick();
      if (hs[0]) d0 = d0 + 1;
      if (hs[1]) d1 = d1 + 1;
      in_data = {d1, d0};
      if (n >= 1) begin
        chk("fair_valid", 32'(out_valid), 32'd1);
        chk("fair_id", 32'(out_id), 32'(exp_id));
        chk("fair_data", out_data, exp_id ? e1 : e0);
        if (exp_id) e1 = e1 + 1; else e0 = e0 + 1;
        exp_id = ~exp_id;
      end
    end
    in_valid = 2'b00;
    repeat (6) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("fair_drained", 32'(out_valid), 32'd0);
    chk("fair_errclr", 32'(err_ovf), 32'd0);

    // Overflow on ch0 with the output stalled
    out_ready = 1'b0;
    in_valid = 2'b01; in_data[31:0] = 32'hC0000001;
    tick();
    in_data[31:0] = 32'hC0000002;
    tick();
    chk("ovf_w1_valid", 32'(out_valid), 32'd1);
    chk("ovf_w1_data", out_data, 32'hC0000001);
    chk("ovf_ready_w3", 32'(in_ready[0]), 32'd1);
    in_data[31:0] = 32'hC0000003;
    tick();
    chk("ovf_ready_full", 32'(in_ready[0]), 32'd0);
    chk("ovf_err_pre", 32'(err_ovf), 32'd0);
    in_data[31:0] = 32'hC0000004;
    tick();
    in_valid = 2'b00;
    chk("ovf_err_set", 32'(err_ovf), 32'd1);
    chk("ovf_hold", out_data, 32'hC0000001);
    out_ready = 1'b1;
    tick();
    chk("ovf_w2", out_data, 32'hC0000002);
    tick();
    chk("ovf_w3", out_data, 32'hC0000003);
    chk("ovf_w3_valid", 32'(out_valid), 32'd1);
    tick();
    chk("ovf_w4_dropped", 32'(out_valid), 32'd0);

    // Clear racing a new ch1 overflow: ch1 set wins, ch0 cleared
    out_ready = 1'b0;
    in_valid = 2'b10;
    in_data[63:32] = 32'hB0000001; tick();
    in_data[63:32] = 32'hB0000002; tick();
    in_data[63:32] = 32'hB0000003; tick();
    in_data[63:32] = 32'hB0000004; err_clr = 1'b1;
    tick();
    chk("clr_race", 32'(err_ovf), 32'd2);
    in_valid = 2'b00;
    tick();
    err_clr = 1'b0;
    chk("clr_plain", 32'(err_ovf), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("clr_drain_b2", out_data, 32'hB0000002);
    repeat (3) tick();
    chk("clr_drained", 32'(out_valid), 32'd0);

    // Mask: ch1 disabled while valid
    mask = 2'b01;
    in_valid = 2'b11; in_data = {32'hE0000000, 32'hD0000000};
    #1;
    chk("mask_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 2'b10;
    tick();
    chk("mask_valid", 32'(out_valid), 32'd1);
    chk("mask_id", 32'(out_id), 32'd0);
    chk("mask_data", out_data, 32'hD0000000);
    tick();
    chk("mask_only_ch0", 32'(out_valid), 32'd0);
    chk("mask_no_err", 32'(err_ovf), 32'd0);
    in_valid = 2'b00; mask = 2'b11;
    tick();

    // Disable with two words queued on ch1 behind the output register
    out_ready = 1'b0;
    in_valid = 2'b10;
    in_data[63:32] = 32'hF0000001; tick();
    in_data[63:32] = 32'hF0000002; tick();
    in_data[63:32] = 32'hF0000003; tick();
    in_valid = 2'b00;
    cfg_en = 1'b0;
    #1;
    chk("dis_ready", 32'(in_ready), 32'd0);
    tick();
    chk("dis_hold_valid", 32'(out_valid), 32'd1);
    chk("dis_hold_data", out_data, 32'hF0000001);
    out_ready = 1'b1;
    tick();
    chk("dis_done", 32'(out_valid), 32'd0);
    cfg_en = 1'b1;
    tick(); tick();
    chk("dis_flushed", 32'(out_valid), 32'd0);

    // Reset asserted while a word is presented
    in_valid = 2'b01; in_data[31:0] = 32'h12345678;
    tick();
    in_valid = 2'b00;
    tick();
    chk("rst_mid_pre", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", out_data, 32'd0);
    chk("rst_mid_id", 32'(out_id), 32'd0);
    chk("rst_mid_err", 32'(err_ovf), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rst_after", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
